frame_link_arbiter: RTL

FRAME_LINK_ARBITER -- requirements
Module: frame_link_arbiter

---
 rtl/frame_link_arbiter_pkg.sv | 22 ++
 rtl/frame_link_arbiter_rr_select.sv | 34 +++
 rtl/frame_link_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/frame_link_arbiter_pkg.sv
// Shared constants for the frame link arbiter and its link interface:
// frame size, PC confirmation codes and one-hot FSM state encoding.
package frame_link_arbiter_pkg;

  localparam int unsigned FRAME_SIZE = 16;

  localparam logic [7:0] CODE_OKAY        = 8'h05;
  localparam logic [7:0] CODE_ERROR       = 8'h04;
  localparam logic [7:0] CODE_FATAL_ERROR = 8'h08;
  localparam logic [7:0] CODE_TIMEOUT     = 8'hFF;

  localparam int unsigned NUM_STATES = 7;

  localparam logic [NUM_STATES-1:0] S_IDLE      = 7'b000_0001;
  localparam logic [NUM_STATES-1:0] S_GRANT     = 7'b000_0010;
  localparam logic [NUM_STATES-1:0] S_SEND      = 7'b000_0100;
  localparam logic [NUM_STATES-1:0] S_WAIT_CONF = 7'b000_1000;
  localparam logic [NUM_STATES-1:0] S_RETRY     = 7'b001_0000;
  localparam logic [NUM_STATES-1:0] S_DONE      = 7'b010_0000;
  localparam logic [NUM_STATES-1:0] S_GUARD     = 7'b100_0000;

endpackage

// File: rtl/frame_link_arbiter_rr_select.sv
// Combinational round-robin selector: first requester at or after start_i,
// wrapping around, returned as a one-hot grant plus its index.
module frame_link_arbiter_rr_select #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int unsigned cand;

  // Walk offsets from farthest to nearest so the nearest pending requester wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      cand = 32'(start_i) + 32'(k);
      if (cand >= N) cand = cand - N;
      if (req_i[cand]) begin
        gnt_o       = '0;
        gnt_o[cand] = 1'b1;
        idx_o       = IW'(cand);
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_link_arbiter.sv
// Frame link arbiter: grants one requester's frame onto the link, waits for the PC
// confirmation and reports the final code. Define FRAME_LINK_ARBITER_RETRY_EN to resend on ERROR.
module frame_link_arbiter
  import frame_link_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned FRAME_SIZE  = frame_link_arbiter_pkg::FRAME_SIZE,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*FRAME_SIZE*8-1:0] req_frame,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              done_valid,
  output logic [7:0]                      done_code,
  input  logic                            link_busy,
  output logic [FRAME_SIZE*8-1:0]         fin,
  output logic                            fin_valid,
  input  logic [7:0]                      conf_from_PC,
  input  logic                            conf_from_PC_valid,
  output logic                            busy
);

  localparam int unsigned FW = FRAME_SIZE * 8;
  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 4 || MAX_RETRY > 255) begin : g_bad_cfg
    $error("frame_link_arbiter: NUM_REQ must be 2..4 and MAX_RETRY at most 255");
  end

  logic [NUM_STATES-1:0] state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         gnt_idx_q, gnt_idx_d;
  logic [FW-1:0]         fin_q, fin_d;
  logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]    done_valid_q, done_valid_d;
  logic [7:0]            done_code_q, done_code_d;
  logic                  fin_valid_q, fin_valid_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  busy_q;

  logic [NUM_REQ-1:0]    sel_gnt;
  logic [IW-1:0]         sel_idx;
  logic                  sel_any;
  logic                  finish;
  logic [7:0]            finish_code;

`ifdef FRAME_LINK_ARBITER_RETRY_EN
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] retry_cnt_q, retry_cnt_d;
  logic          resend_q, resend_d;
`endif

  frame_link_arbiter_rr_select #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_select (
    .req_i   (req_valid),
    .start_i (ptr_q),
    .gnt_o   (sel_gnt),
    .idx_o   (sel_idx),
    .any_o   (sel_any)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_idx_d    = gnt_idx_q;
    fin_d        = fin_q;
    req_ready_d  = '0;
    done_valid_d = '0;
    done_code_d  = done_code_q;
    fin_valid_d  = 1'b0;
    tmo_d        = tmo_q;
    finish       = 1'b0;
    finish_code  = CODE_OKAY;
`ifdef FRAME_LINK_ARBITER_RETRY_EN
    retry_cnt_d  = retry_cnt_q;
    resend_d     = resend_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req_valid && !link_busy) state_d = S_GRANT;
      end
      S_GRANT: begin
        // A requester may have withdrawn since IDLE; with nobody left, go back quietly.
        if (sel_any) begin
          gnt_idx_d   = sel_idx;
          fin_d       = req_frame[FW*int'(sel_idx) +: FW];
          req_ready_d = sel_gnt;
          ptr_d       = (sel_idx == IW'(NUM_REQ - 1)) ? '0 : sel_idx + IW'(1);
`ifdef FRAME_LINK_ARBITER_RETRY_EN
          retry_cnt_d = '0;
          resend_d    = 1'b0;
`endif
          state_d     = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (!link_busy) begin
          fin_valid_d = 1'b1;
          tmo_d       = '0;
          state_d     = S_WAIT_CONF;
        end
      end
      S_WAIT_CONF: begin
        // A confirmation on the final timeout cycle takes priority over the timeout.
        if (conf_from_PC_valid) begin
`ifdef FRAME_LINK_ARBITER_RETRY_EN
          if (conf_from_PC == CODE_ERROR) begin
            state_d = S_RETRY;
          end else begin
            finish      = 1'b1;
            finish_code = conf_from_PC;
          end
`else
          finish      = 1'b1;
          finish_code = conf_from_PC;
`endif
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          finish      = 1'b1;
          finish_code = CODE_TIMEOUT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
`ifdef FRAME_LINK_ARBITER_RETRY_EN
      S_RETRY: begin
        if (retry_cnt_q == RW'(MAX_RETRY)) begin
          finish      = 1'b1;
          finish_code = CODE_ERROR;
        end else begin
          retry_cnt_d = retry_cnt_q + RW'(1);
          resend_d    = 1'b1;
          state_d     = S_GUARD;
        end
      end
`endif
      S_DONE: begin
        state_d = S_GUARD;
      end
      S_GUARD: begin
        // Wait out a held confirmation so it is never consumed twice.
        if (!conf_from_PC_valid) begin
`ifdef FRAME_LINK_ARBITER_RETRY_EN
          state_d  = resend_q ? S_SEND : S_IDLE;
          resend_d = 1'b0;
`else
          state_d = S_IDLE;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (finish) begin
      state_d      = S_DONE;
      done_valid_d = NUM_REQ'(1) << gnt_idx_q;
      done_code_d  = finish_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      gnt_idx_q    <= '0;
      fin_q        <= '0;
      req_ready_q  <= '0;
      done_valid_q <= '0;
      done_code_q  <= '0;
      fin_valid_q  <= 1'b0;
      tmo_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_idx_q    <= gnt_idx_d;
      fin_q        <= fin_d;
      req_ready_q  <= req_ready_d;
      done_valid_q <= done_valid_d;
      done_code_q  <= done_code_d;
      fin_valid_q  <= fin_valid_d;
      tmo_q        <= tmo_d;
      busy_q       <= (state_d != S_IDLE);
    end
  end

`ifdef FRAME_LINK_ARBITER_RETRY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt_q <= '0;
      resend_q    <= 1'b0;
    end else begin
      retry_cnt_q <= retry_cnt_d;
      resend_q    <= resend_d;
    end
  end
`endif

  assign req_ready  = req_ready_q;
  assign done_valid = done_valid_q;
  assign done_code  = done_code_q;
  assign fin        = fin_q;
  assign fin_valid  = fin_valid_q;
  assign busy       = busy_q;

endmodule
